// File: rtl/stream_demux.sv
// stream_demux: registered 1-to-N stream demultiplexer with valid/ready on every port.
// Each accepted word is routed by in_sel (or broadcast) into a one-entry output slot per
// channel. Words for a nonexistent channel are accepted, dropped, flagged and counted.
module stream_demux #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned CHANNELS = 5,
  parameter int unsigned SEL_W    = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [WIDTH-1:0]          in_data,
  input  logic [SEL_W-1:0]          in_sel,
  input  logic                      in_bcast,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic [CHANNELS*WIDTH-1:0] out_data,
  output logic [CHANNELS-1:0]       out_valid,
  input  logic [CHANNELS-1:0]       out_ready,
  output logic                      err,
  output logic [7:0]                drop_cnt
);

  // Extra bit so the range compare also works when 2^SEL_W == CHANNELS.
  localparam logic [SEL_W:0] NumChan = (SEL_W+1)'(CHANNELS);

  logic [CHANNELS*WIDTH-1:0] data_q, data_d;
  logic [CHANNELS-1:0]       valid_q, valid_d;
  logic                      err_q, err_d;
  logic [7:0]                drop_cnt_q, drop_cnt_d;

  logic [CHANNELS-1:0] can_load;
  logic [CHANNELS-1:0] sel_hit;
  logic [CHANNELS-1:0] load;
  logic                sel_ok;
  logic                xfer;
  logic                drop;

  // Routing: decode destination, compute readiness (independent of in_valid) and slot loads.
  always_comb begin
    can_load = ~valid_q | out_ready;
    sel_ok   = {1'b0, in_sel} < NumChan;
    sel_hit  = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      sel_hit[k] = (in_sel == SEL_W'(k));
    end

    if (in_bcast) begin
      // All-or-nothing: a broadcast waits until every slot can take it.
      in_ready = &can_load;
    end else if (sel_ok) begin
      in_ready = |(sel_hit & can_load);
    end else begin
      // Out-of-range words are always swallowed.
      in_ready = 1'b1;
    end

    xfer = in_valid & in_ready;
    load = '0;
    if (xfer) begin
      load = in_bcast ? {CHANNELS{1'b1}} : sel_hit;
    end
    drop = xfer & ~in_bcast & ~sel_ok;
  end

  // Slot next state: a load wins over a drain so a simultaneous drain+load leaves no bubble.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    for (int k = 0; k < CHANNELS; k++) begin
      if (load[k]) begin
        data_d[k*WIDTH +: WIDTH] = in_data;
        valid_d[k]               = 1'b1;
      end else if (valid_q[k] && out_ready[k]) begin
        data_d[k*WIDTH +: WIDTH] = '0;
        valid_d[k]               = 1'b0;
      end
    end
  end

  // Drop reporting: one-cycle err pulse per dropped word, saturating drop counter.
  always_comb begin
    err_d      = drop;
    drop_cnt_d = drop_cnt_q;
    if (drop && (drop_cnt_q != 8'hFF)) begin
      drop_cnt_d = drop_cnt_q + 8'd1;
    end
  end

  // State registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q     <= '0;
      valid_q    <= '0;
      err_q      <= 1'b0;
      drop_cnt_q <= 8'd0;
    end else begin
      data_q     <= data_d;
      valid_q    <= valid_d;
      err_q      <= err_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign out_data  = data_q;
  assign out_valid = valid_q;
  assign err       = err_q;
  assign drop_cnt  = drop_cnt_q;

endmodule
